// File: rtl/mem_bank_arbiter_pkg.sv
// rtl/mem_bank_arbiter_pkg.sv - shared lane types and constants for the bank arbiter
package mem_bank_arbiter_pkg;

  localparam int NUM_LANES  = 2;
  localparam int LANE_ID_W  = 1;
  localparam int BUSY_CNT_W = 16;
  localparam logic [BUSY_CNT_W-1:0] BUSY_CNT_MAX = '1;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // A lone requester always wins; on contention the lane not served last wins.
  function automatic logic [NUM_LANES-1:0] rr_pick(input logic [NUM_LANES-1:0] valid,
                                                   input lane_e last);
    logic [NUM_LANES-1:0] pick;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = (last == LANE1) ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/mem_bank_arbiter_rr_arb2.sv
// rtl/mem_bank_arbiter_rr_arb2.sv - two-lane round-robin arbiter with combinational grant
module rr_arb2
  import mem_bank_arbiter_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] valid,
  output logic [NUM_LANES-1:0] grant,
  output logic                 gnt_id
);

  lane_e last_q, last_d;

  always_comb begin
    grant  = rr_pick(valid, last_q);
    gnt_id = grant[1];
    last_d = last_q;
    // A grant implies the lane is valid, so any grant is a completed transfer.
    if (|grant) last_d = lane_e'(gnt_id);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_q <= LANE1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mem_bank_arbiter.sv
// rtl/mem_bank_arbiter.sv - shares one SRAM bank's read and write ports between two lanes
module mem_bank_arbiter
  import mem_bank_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_LANES-1:0]        rd_req_valid,
  input  logic [NUM_LANES*ADDR_W-1:0] rd_req_addr,
  output logic [NUM_LANES-1:0]        rd_req_ready,
  output logic                        rd_rsp_valid,
  output logic [LANE_ID_W-1:0]        rd_rsp_id,
  output logic [DATA_W-1:0]           rd_rsp_data,
  input  logic [NUM_LANES-1:0]        wr_req_valid,
  input  logic [NUM_LANES*ADDR_W-1:0] wr_req_addr,
  input  logic [NUM_LANES*DATA_W-1:0] wr_req_data,
  output logic [NUM_LANES-1:0]        wr_req_ready,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_waddr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [ADDR_W-1:0]           mem_raddr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [BUSY_CNT_W-1:0]       busy_cnt
);

  logic [NUM_LANES-1:0] rd_grant, wr_grant;
  logic                 rd_gnt_id, wr_gnt_id;

  rr_arb2 u_rd_arb (
    .clock  (clock),
    .reset  (reset),
    .valid  (rd_req_valid),
    .grant  (rd_grant),
    .gnt_id (rd_gnt_id)
  );

  rr_arb2 u_wr_arb (
    .clock  (clock),
    .reset  (reset),
    .valid  (wr_req_valid),
    .grant  (wr_grant),
    .gnt_id (wr_gnt_id)
  );

  assign rd_req_ready = rd_grant;
  assign wr_req_ready = wr_grant;

  // gnt_id is 0 when idle, so the muxes fall back to the lane-0 inputs.
  assign mem_raddr = rd_gnt_id ? rd_req_addr[ADDR_W +: ADDR_W] : rd_req_addr[0 +: ADDR_W];
  assign mem_waddr = wr_gnt_id ? wr_req_addr[ADDR_W +: ADDR_W] : wr_req_addr[0 +: ADDR_W];
  assign mem_wdata = wr_gnt_id ? wr_req_data[DATA_W +: DATA_W] : wr_req_data[0 +: DATA_W];
  assign mem_we    = |wr_grant;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [LANE_ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic [BUSY_CNT_W-1:0] busy_q, busy_d;

  always_comb begin
    rsp_valid_d = |rd_grant;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    if (|rd_grant) begin
      rsp_id_d   = rd_gnt_id;
      rsp_data_d = mem_rdata;
    end
    if (((&rd_req_valid) | (&wr_req_valid)) && (busy_q != BUSY_CNT_MAX))
      busy_d = busy_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_id    = rsp_id_q;
  assign rd_rsp_data  = rsp_data_q;
  assign busy_cnt     = busy_q;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb/tb_mem_bank_arbiter.sv - randomized and directed bench for mem_bank_arbiter against a lane-level model
module tb_mem_bank_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      rd_req_valid, wr_req_valid;
  logic [2*AW-1:0] rd_req_addr, wr_req_addr;
  logic [2*DW-1:0] wr_req_data;
  logic [1:0]      rd_req_ready, wr_req_ready;
  logic            rd_rsp_valid;
  logic [0:0]      rd_rsp_id;
  logic [DW-1:0]   rd_rsp_data;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr, mem_raddr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [15:0]     busy_cnt;

  mem_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .rd_req_valid (rd_req_valid),
    .rd_req_addr  (rd_req_addr),
    .rd_req_ready (rd_req_ready),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_id    (rd_rsp_id),
    .rd_rsp_data  (rd_rsp_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_ready (wr_req_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .busy_cnt     (busy_cnt)
  );

  always #5 clock = ~clock;

  // Bank SRAM: asynchronous read, write committed just after the edge.
  logic [DW-1:0] sram_mem [4096];
  assign mem_rdata = sram_mem[mem_raddr];

  // Reference model state
  logic [DW-1:0] ref_mem [4096];
  bit            ref_last_rd, ref_last_wr;
  bit            ref_rsp_v;
  bit            ref_rsp_id;
  logic [DW-1:0] ref_rsp_d;
  int            ref_busy;
  logic [1:0]    g_rd, g_wr;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [1:0] ref_grant(input logic [1:0] v, input bit last);
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rd_req_valid = 2'b00;
    wr_req_valid = 2'b00;
  endtask

  task automatic set_rd(input int l, input bit v, input logic [AW-1:0] a);
    rd_req_valid[l]        = v;
    rd_req_addr[l*AW +: AW] = a;
  endtask

  task automatic set_wr(input int l, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req_valid[l]         = v;
    wr_req_addr[l*AW +: AW] = a;
    wr_req_data[l*DW +: DW] = d;
  endtask

  task automatic ref_reset();
    ref_last_rd = 1'b1;
    ref_last_wr = 1'b1;
    ref_rsp_v   = 1'b0;
    ref_busy    = 0;
  endtask

  // Called at a negedge with reset low; returns at the next negedge.
  task automatic step();
    int            rl, wl;
    logic [AW-1:0] ra, wa, dut_wa;
    logic [DW-1:0] wd, dut_wd;
    bit            dut_we, conflict;
    #1;
    g_rd = ref_grant(rd_req_valid, ref_last_rd);
    g_wr = ref_grant(wr_req_valid, ref_last_wr);
    rl = g_rd[1] ? 1 : 0;
    wl = g_wr[1] ? 1 : 0;
    ra = rd_req_addr[rl*AW +: AW];
    wa = wr_req_addr[wl*AW +: AW];
    wd = wr_req_data[wl*DW +: DW];
    check("rd_ready", rd_req_ready, g_rd);
    check("wr_ready", wr_req_ready, g_wr);
    check("mem_raddr", mem_raddr, ra);
    check("mem_we", mem_we, |g_wr);
    check("mem_waddr", mem_waddr, wa);
    check("mem_wdata", mem_wdata, wd);
    check("rsp_valid", rd_rsp_valid, ref_rsp_v);
    if (ref_rsp_v) begin
      check("rsp_id", rd_rsp_id, ref_rsp_id);
      check("rsp_data", rd_rsp_data, ref_rsp_d);
    end
    check("busy_cnt", busy_cnt, ref_busy);
    dut_we   = mem_we;
    dut_wa   = mem_waddr;
    dut_wd   = mem_wdata;
    conflict = (&rd_req_valid) || (&wr_req_valid);
    @(posedge clock);
    #1;
    if (dut_we) sram_mem[dut_wa] = dut_wd;
    ref_rsp_v = |g_rd;
    if (|g_rd) begin
      ref_rsp_id  = rl[0];
      ref_rsp_d   = ref_mem[ra];
      ref_last_rd = rl[0];
    end
    if (|g_wr) begin
      ref_mem[wa] = wd;
      ref_last_wr = wl[0];
    end
    if (conflict && ref_busy < 65535) ref_busy++;
    @(negedge clock);
  endtask

  // Called at a negedge; asserts reset asynchronously, releases at the next negedge.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    check("rst_rsp_valid", rd_rsp_valid, 1'b0);
    check("rst_busy_cnt", busy_cnt, 16'h0000);
    ref_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    rd_req_addr = '0;
    wr_req_addr = '0;
    wr_req_data = '0;
    idle();
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = 32'hA5A5_0000 | i;
      ref_mem[i]  = 32'hA5A5_0000 | i;
    end
    ref_reset();
    @(negedge clock);
    do_reset();

    // Single read after reset
    set_rd(0, 1'b1, 12'h010);
    step();
    idle();
    check("first_rsp_data", rd_rsp_data, 32'hA5A5_0010);
    step();

    // Contending reads alternate lanes
    do_reset();
    set_rd(0, 1'b1, 12'h100);
    set_rd(1, 1'b1, 12'h101);
    repeat (4) step();
    idle();
    step();
    check("busy_after_4", busy_cnt, 16'd4);

    // Same-cycle write and read of one address returns the old contents
    set_wr(1, 1'b1, 12'h020, 32'h1234_5678);
    set_rd(0, 1'b1, 12'h020);
    step();
    wr_req_valid = 2'b00;
    check("old_value", rd_rsp_data, 32'hA5A5_0020);
    step();
    idle();
    check("new_value", rd_rsp_data, 32'h1234_5678);
    step();

    // Contending writes to one address: lane 0 then lane 1
    do_reset();
    set_wr(0, 1'b1, 12'h030, 32'd1);
    set_wr(1, 1'b1, 12'h030, 32'd2);
    step();
    wr_req_valid[0] = 1'b0;
    step();
    idle();
    set_rd(0, 1'b1, 12'h030);
    step();
    idle();
    check("wr_final", rd_rsp_data, 32'd2);
    step();

    // Reset with a response in flight, then contention favours lane 0
    set_rd(0, 1'b1, 12'h040);
    step();
    do_reset();
    set_rd(0, 1'b1, 12'h041);
    set_rd(1, 1'b1, 12'h042);
    #1;
    check("post_rst_grant", rd_req_ready, 2'b01);
    step();
    step();
    idle();
    step();

    // Randomized traffic with hold-until-ready requesters
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < 2; l++) begin
        if (!(rd_req_valid[l] && !g_rd[l]))
          set_rd(l, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)));
        if (!(wr_req_valid[l] && !g_wr[l]))
          set_wr(l, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), $urandom);
      end
      step();
    end
    idle();
    step();

    // Busy counter saturation
    do_reset();
    rd_req_valid = 2'b11;
    repeat (65534) @(posedge clock);
    @(negedge clock);
    check("busy_fffe", busy_cnt, 16'hFFFE);
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("busy_sat", busy_cnt, 16'hFFFF);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bank_arbiter.md
# mem_bank_arbiter

Arbitrates one memory-access-controller SRAM bank (4096 words, separate read and write ports, single clock) between two requesters: lane 0 and lane 1 of the streaming-ops datapath. Each lane has independent read and write request channels. Each port uses round-robin arbitration with valid/ready handshakes. Read data returns one cycle after grant, tagged with the lane id. Sits between the streaming-ops controllers and the `sram` instance inside the PE.

## Interface
Parameters:
- ADDR_W, default 12: bank address width; must match `MEM_ACC_CONT_BANK_ADDRESS_RANGE`.
- DATA_W, default 32: bank data width; must match `MEM_ACC_CONT_BANK_DATA_RANGE`.

Ports (one clock; reset is asynchronous and active-high):
- clock, input, 1: bank clock.
- reset, input, 1: asynchronous active-high reset.
- rd_req_valid, input, 2: per-lane read request.
- rd_req_addr, input, 2*ADDR_W: per-lane read address; lane i is at [i*ADDR_W +: ADDR_W].
- rd_req_ready, output, 2: per-lane read grant.
- rd_rsp_valid, output, 1: read data valid.
- rd_rsp_id, output, 1: lane that owns rd_rsp_data.
- rd_rsp_data, output, DATA_W: registered read data.
- wr_req_valid, input, 2: per-lane write request.
- wr_req_addr, input, 2*ADDR_W: per-lane write address.
- wr_req_data, input, 2*DATA_W: per-lane write data.
- wr_req_ready, output, 2: per-lane write grant.
- mem_we, output, 1: to sram WE.
- mem_waddr, output, ADDR_W: to sram WriteAddress.
- mem_wdata, output, DATA_W: to sram WriteBus.
- mem_raddr, output, ADDR_W: to sram ReadAddress.
- mem_rdata, input, DATA_W: from sram ReadBus.
- busy_cnt, output, 16: saturating count of cycles with any conflict (both lanes valid on either port).

## Operation
- Read port and write port are arbitrated independently by identical round-robin units.
- Each unit holds one state bit, `last`: the lane granted most recently. Reset value is 1, so lane 0 wins the first conflict.
- Grant rules, per port:
  - Only one lane valid: that lane is granted.
  - Both lanes valid: grant lane `!last`.
  - Neither valid: no grant, `last` unchanged.
- Grant is combinational: ready[i] = grant[i]. A transfer is valid && ready. `last` updates only on a transfer.
- Requesters must hold valid, addr and data stable until ready. The arbiter never deasserts ready for a valid lane mid-cycle.
- Write path:
  - mem_we = any write transfer.
  - mem_waddr and mem_wdata are muxed from the granted lane.
  - When idle, mem_waddr and mem_wdata hold the lane-0 inputs and mem_we = 0.
- Read path:
  - mem_raddr is muxed from the granted lane; it holds the lane-0 address when idle.
  - On a read transfer in cycle N, mem_rdata is captured at the end of cycle N. rd_rsp_valid=1, rd_rsp_id=lane and rd_rsp_data are presented in cycle N+1.
  - There is no response backpressure; the requester must accept the response.
- Same-address read and write in the same cycle: the read returns the OLD contents, because the write commits at the clock edge. There is no forwarding.
- Lane 0 writing and lane 1 reading the same address in the same cycle is legal and behaves as above.
- busy_cnt increments when (&rd_req_valid) | (&wr_req_valid), and saturates at 16'hFFFF.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - rd_rsp_valid=0, rd_rsp_id=0, rd_rsp_data=0;
  - both `last` bits = 1;
  - busy_cnt=0.
- Reset mid-operation: an in-flight response is dropped (rd_rsp_valid=0 on the next edge). A write granted in the same cycle as reset assertion is not guaranteed to commit.
- Read latency is 1 cycle from grant to response. Sustained throughput is 1 read and 1 write per cycle.
- Fairness: with a lane continuously valid, the worst-case wait before grant is 1 cycle.
- Combinational paths valid→ready and addr→mem_raddr must fit in the clock period minus the 0.3 ns memory input delay.
- mem_rdata arrives 0.3 ns after mem_raddr settles and is sampled at the next posedge.

## Structure
- Add to `mem_acc_cont.vh`:
  - `MEM_ACC_CONT_NUM_LANES` (2);
  - `MEM_ACC_CONT_LANE_ID_RANGE`;
  - `MEM_ACC_CONT_BUSY_CNT_RANGE`.
- Address and data widths come from the existing bank ranges.
- One sub-module, `rr_arb2`: inputs clock, reset, valid[1:0]; outputs grant[1:0], gnt_id. It contains the `last` flop. Instantiate it twice, once per port.
- The response register and busy counter live in the top module.

## Test plan
- After reset, lane 0 reads address 12'h010 (preloaded with 32'hA5A5_0010) → rd_req_ready=2'b01 the same cycle; next cycle rd_rsp_valid=1, rd_rsp_id=0, rd_rsp_data=32'hA5A5_0010.
- Both lanes hold read requests for 4 cycles → grants alternate 0,1,0,1; responses return ids 0,1,0,1 one cycle later; busy_cnt=4.
- Lane 1 writes 12'h020=32'h1234_5678 while lane 0 reads 12'h020 in the same cycle → the read returns the old value; a re-read next cycle returns 32'h1234_5678.
- Both lanes write to 12'h030 (lane 0 data 1, lane 1 data 2) for one cycle each, contending → lane 0 commits first, then lane 1; final contents are 2; mem_we is high for 2 cycles.
- Assert reset in the cycle after a read grant → rd_rsp_valid=0 and busy_cnt=0; after release, the first contention grants lane 0.
- Force 65540 conflict cycles → busy_cnt saturates at 16'hFFFF.
